// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port RAM (1-cycle registered read) between N_REQ clients.
// Optional RAM_ARB_LOCK_EN adds a per-requester lock input that freezes arbitration on the holder.
module ram_rr_arbiter #(
  parameter int N_REQ      = 2,
  parameter int DATA_WIDTH = 8,
  parameter int N_WORDS    = 16,
  localparam int AW = $clog2(N_WORDS),
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0]            wr,
  input  logic [N_REQ*AW-1:0]         addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] wdata,
`ifdef RAM_ARB_LOCK_EN
  input  logic [N_REQ-1:0]            lock,
`endif
  output logic [N_REQ-1:0]            gnt,
  output logic [N_REQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]       rdata,
  output logic                        ram_we,
  output logic                        ram_re,
  output logic [AW-1:0]               ram_address,
  output logic [DATA_WIDTH-1:0]       ram_data_in,
  input  logic [DATA_WIDTH-1:0]       ram_data_out
);

  logic [PW-1:0]    ptr;
  logic [PW-1:0]    winner;
  logic [PW-1:0]    ptr_nxt;
  logic             any;
  logic [N_REQ-1:0] rvalid_q;

`ifdef RAM_ARB_LOCK_EN
  logic          locked;
  logic [PW-1:0] lock_id;
`endif

  // Search from ptr upward with wrap; first requester found wins.
  always_comb begin
    logic [PW:0] sum;
    logic [PW-1:0] idx;
    any    = 1'b0;
    winner = '0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N_REQ))
        sum = sum - (PW+1)'(N_REQ);
      idx = sum[PW-1:0];
      if (!any && req[idx]) begin
        any    = 1'b1;
        winner = idx;
      end
    end
`ifdef RAM_ARB_LOCK_EN
    // A held lock overrides round-robin; dropping req falls back to normal search.
    if (locked && req[lock_id]) begin
      any    = 1'b1;
      winner = lock_id;
    end
`endif
    if (rst)
      any = 1'b0;
  end

  always_comb begin
    gnt = '0;
    for (int i = 0; i < N_REQ; i++)
      gnt[i] = any && (winner == PW'(i));
    ram_we      = any && wr[winner];
    ram_re      = any && !wr[winner];
    ram_address = any ? addr[int'(winner)*AW +: AW] : '0;
    ram_data_in = any ? wdata[int'(winner)*DATA_WIDTH +: DATA_WIDTH] : '0;
    ptr_nxt     = (int'(winner) == N_REQ-1) ? '0 : winner + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      rvalid_q <= '0;
    end else begin
      if (any)
        ptr <= ptr_nxt;
      rvalid_q <= gnt & {N_REQ{ram_re}};
    end
  end

`ifdef RAM_ARB_LOCK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      locked  <= 1'b0;
      lock_id <= '0;
    end else begin
      locked  <= any && lock[winner];
      lock_id <= winner;
    end
  end
`endif

  // A read issued just before reset must not report data.
  assign rvalid = rvalid_q & {N_REQ{~rst}};
  assign rdata  = ram_data_out;

endmodule
